mem_port_ctrl: RTL



---
 rtl/mem_port_ctrl.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: sequences instruction fetches and loads/stores onto the unified MIPS memory.
// Define MEM_PORT_SUBWORD_EN to add byte/half loads and read-modify-write byte/half stores.
module mem_port_ctrl #(
  parameter int unsigned MEM_WORDS = 128,
  parameter logic [31:0] PC_START  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic        data_signed,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_rdata,
  output logic [31:0] last_pc,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_dataaddr,
  output logic        mem_iord,
  output logic        mem_irwrite,
  output logic        mem_we,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_instr,
  input  logic [31:0] mem_readdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_STORE,
`ifdef MEM_PORT_SUBWORD_EN
    S_RMW_RD,
    S_RMW_WR,
`endif
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        is_fetch_q, is_fetch_d;
  logic        is_load_q, is_load_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_instr_q, resp_instr_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] mem_pc_q, mem_pc_d;
  logic [31:0] mem_dataaddr_q, mem_dataaddr_d;
  logic        mem_iord_q, mem_iord_d;
  logic        mem_irwrite_q, mem_irwrite_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;

  logic        fetch_bad;
  logic        data_bad;
  logic [31:0] load_ext;

  always_comb begin
    fetch_bad = (fetch_pc[1:0] != 2'b00) || (fetch_pc >= ADDR_LIMIT);
    data_bad  = (data_addr >= ADDR_LIMIT);
`ifdef MEM_PORT_SUBWORD_EN
    case (data_size)
      2'b00:   data_bad = data_bad;
      2'b01:   data_bad = data_bad || data_addr[0];
      2'b10:   data_bad = data_bad || (data_addr[1:0] != 2'b00);
      default: data_bad = 1'b1;
    endcase
`else
    data_bad = data_bad || (data_size != 2'b10) || (data_addr[1:0] != 2'b00);
`endif
  end

`ifdef MEM_PORT_SUBWORD_EN
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] rmw_merged;

  always_comb begin
    lane_b = mem_readdata[{addr_lo_q, 3'b000} +: 8];
    lane_h = mem_readdata[{addr_lo_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_ext = mem_readdata;
    endcase
    rmw_merged = mem_readdata;
    if (size_q == 2'b00) rmw_merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 rmw_merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end
`else
  logic unused_data_signed;
  assign unused_data_signed = data_signed;
  assign load_ext           = mem_readdata;
`endif

  always_comb begin
    state_d         = state_q;
    is_fetch_d      = is_fetch_q;
    is_load_d       = is_load_q;
    err_d           = err_q;
    resp_instr_d    = resp_instr_q;
    resp_rdata_d    = resp_rdata_q;
    last_pc_d       = last_pc_q;
    mem_pc_d        = mem_pc_q;
    mem_dataaddr_d  = mem_dataaddr_q;
    mem_writedata_d = mem_writedata_q;
`ifdef MEM_PORT_SUBWORD_EN
    size_d    = size_q;
    signed_d  = signed_q;
    addr_lo_d = addr_lo_q;
    wdata_d   = wdata_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          is_fetch_d = 1'b0;
          is_load_d  = !data_we;
          err_d      = data_bad;
`ifdef MEM_PORT_SUBWORD_EN
          size_d    = data_size;
          signed_d  = data_signed;
          addr_lo_d = data_addr[1:0];
          wdata_d   = data_wdata[15:0];
`endif
          if (data_bad) begin
            state_d = S_RESP;
          end else begin
            mem_dataaddr_d = {data_addr[31:2], 2'b00};
            if (!data_we) state_d = S_LOAD;
`ifdef MEM_PORT_SUBWORD_EN
            else if (data_size != 2'b10) state_d = S_RMW_RD;
`endif
            else begin
              state_d         = S_STORE;
              mem_writedata_d = data_wdata;
            end
          end
        end else if (fetch_req) begin
          is_fetch_d = 1'b1;
          is_load_d  = 1'b0;
          err_d      = fetch_bad;
          last_pc_d  = fetch_pc;
          if (fetch_bad) begin
            state_d = S_RESP;
          end else begin
            state_d  = S_FETCH;
            mem_pc_d = fetch_pc;
          end
        end
      end
      S_FETCH, S_LOAD, S_STORE: state_d = S_RESP;
`ifdef MEM_PORT_SUBWORD_EN
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: begin
        state_d         = S_RESP;
        mem_writedata_d = rmw_merged;
      end
`endif
      S_RESP: begin
        state_d = S_IDLE;
        if (!err_q && is_fetch_q) resp_instr_d = mem_instr;
        if (!err_q && is_load_q)  resp_rdata_d = load_ext;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d        = (state_d != S_IDLE);
    resp_valid_d  = (state_d == S_RESP);
    resp_err_d    = (state_d == S_RESP) && err_d;
    mem_iord_d    = 1'b0;
    mem_irwrite_d = 1'b0;
    mem_we_d      = 1'b0;
    case (state_d)
      S_FETCH: mem_irwrite_d = 1'b1;
      S_LOAD:  mem_iord_d    = 1'b1;
      S_STORE: begin
        mem_iord_d = 1'b1;
        mem_we_d   = 1'b1;
      end
`ifdef MEM_PORT_SUBWORD_EN
      S_RMW_RD: mem_iord_d = 1'b1;
      S_RMW_WR: begin
        mem_iord_d = 1'b1;
        mem_we_d   = 1'b1;
      end
`endif
      default: mem_iord_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      is_fetch_q      <= 1'b0;
      is_load_q       <= 1'b0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_instr_q    <= '0;
      resp_rdata_q    <= '0;
      last_pc_q       <= PC_START;
      mem_pc_q        <= PC_START;
      mem_dataaddr_q  <= '0;
      mem_iord_q      <= 1'b0;
      mem_irwrite_q   <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_writedata_q <= '0;
`ifdef MEM_PORT_SUBWORD_EN
      size_q    <= '0;
      signed_q  <= 1'b0;
      addr_lo_q <= '0;
      wdata_q   <= '0;
`endif
    end else begin
      state_q         <= state_d;
      is_fetch_q      <= is_fetch_d;
      is_load_q       <= is_load_d;
      err_q           <= err_d;
      busy_q          <= busy_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_instr_q    <= resp_instr_d;
      resp_rdata_q    <= resp_rdata_d;
      last_pc_q       <= last_pc_d;
      mem_pc_q        <= mem_pc_d;
      mem_dataaddr_q  <= mem_dataaddr_d;
      mem_iord_q      <= mem_iord_d;
      mem_irwrite_q   <= mem_irwrite_d;
      mem_we_q        <= mem_we_d;
      mem_writedata_q <= mem_writedata_d;
`ifdef MEM_PORT_SUBWORD_EN
      size_q    <= size_d;
      signed_q  <= signed_d;
      addr_lo_q <= addr_lo_d;
      wdata_q   <= wdata_d;
`endif
    end
  end

  // Memory outputs arrive one cycle after the access, so RESP passes them straight
  // through and the registers only hold them for later cycles.
  assign resp_instr   = (state_q == S_RESP && is_fetch_q && !err_q) ? mem_instr : resp_instr_q;
  assign resp_rdata   = (state_q == S_RESP && is_load_q && !err_q) ? load_ext : resp_rdata_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign last_pc      = last_pc_q;
  assign mem_pc       = mem_pc_q;
  assign mem_dataaddr = mem_dataaddr_q;
  assign mem_iord     = mem_iord_q;
  // Write strobes are blocked combinationally so a reset cycle never modifies memory.
  assign mem_irwrite  = mem_irwrite_q && !reset;
  assign mem_we       = mem_we_q && !reset;
`ifdef MEM_PORT_SUBWORD_EN
  assign mem_writedata = (state_q == S_RMW_WR) ? rmw_merged : mem_writedata_q;
`else
  assign mem_writedata = mem_writedata_q;
`endif

endmodule
